// File: rtl/smem_sched_pkg.sv
// Shared state encoding and default sizes for the shared-memory access scheduler.
// Both the top level and the round-robin picker import this package.
package smem_sched_pkg;

  localparam int SMEM_REQ_WIDTH  = 10;
  localparam int SMEM_ADDR_WIDTH = 8;
  localparam int SMEM_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACCESS    = 2'd1,
    READ_WAIT = 2'd2
  } sched_state_e;

  // Width of a requester index; a lone requester still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/smem_access_scheduler_rr_pick.sv
// Combinational round-robin winner selection. Requests at or above ptr take
// precedence; if there are none, the search wraps around to the lowest request.
module rr_pick
  import smem_sched_pkg::*;
#(
  parameter  int N  = SMEM_REQ_WIDTH,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  onehot_o,
  output logic [IW-1:0] idx_o
);

  logic [N-1:0] masked;
  logic [N-1:0] pick;

  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    masked   = '0;
    pick     = '0;
    onehot_o = '0;
    idx_o    = '0;

    for (int i = 0; i < N; i++) begin
      masked[i] = req_i[i] && (IW'(i) >= ptr_i);
    end
    pick = (masked != '0) ? masked : req_i;

    // Scanning downward lets the lowest set bit overwrite any higher one.
    for (int i = N - 1; i >= 0; i--) begin
      if (pick[i]) begin
        onehot_o    = '0;
        onehot_o[i] = 1'b1;
        idx_o       = IW'(i);
      end
    end
  end

endmodule

// File: rtl/smem_access_scheduler.sv
// Arbitrates many requesters onto one single-port memory bank, one access at a time,
// and returns read data tagged with the requester index one cycle after the grant.
module smem_access_scheduler
  import smem_sched_pkg::*;
#(
  parameter  int Req_Width  = SMEM_REQ_WIDTH,
  parameter  int ADDR_WIDTH = SMEM_ADDR_WIDTH,
  parameter  int DATA_WIDTH = SMEM_DATA_WIDTH,
  localparam int IdW        = idx_width(Req_Width)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [Req_Width-1:0]            req,
  input  logic [Req_Width-1:0]            req_we,
  input  logic [Req_Width*ADDR_WIDTH-1:0] req_addr,
  input  logic [Req_Width*DATA_WIDTH-1:0] req_wdata,
  output logic [Req_Width-1:0]            gnt,
  output logic                            mem_en,
  output logic                            mem_we,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  output logic [DATA_WIDTH-1:0]           mem_wdata,
  input  logic [DATA_WIDTH-1:0]           mem_rdata,
  output logic                            rsp_valid,
  output logic [IdW-1:0]                  rsp_id,
  output logic [DATA_WIDTH-1:0]           rsp_rdata,
  output logic                            busy
);

  sched_state_e          state_q;
  logic [IdW-1:0]        ptr_q;
  logic [IdW-1:0]        ptr_d;
  logic [IdW-1:0]        id_q;
  logic [Req_Width-1:0]  gnt_q;
  logic                  mem_en_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic                  rsp_valid_q;
  logic [IdW-1:0]        rsp_id_q;

  logic [Req_Width-1:0]  win_onehot;
  logic [IdW-1:0]        win_idx;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  rr_pick #(
    .N(Req_Width)
  ) u_rr_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .onehot_o(win_onehot),
    .idx_o   (win_idx)
  );

  // Explicit wrap: Req_Width need not be a power of two.
  assign ptr_d     = (win_idx == IdW'(Req_Width - 1)) ? '0 : win_idx + 1'b1;
  assign sel_addr  = req_addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_wdata = req_wdata[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      gnt_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      // NOTE: non-blocking updates so every register samples values from before this edge.
      gnt_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      rsp_valid_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (req != '0) begin
            state_q     <= ACCESS;
            ptr_q       <= ptr_d;
            id_q        <= win_idx;
            gnt_q       <= win_onehot;
            mem_en_q    <= 1'b1;
            mem_we_q    <= req_we[win_idx];
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
          end
        end
        ACCESS: begin
          if (mem_we_q) begin
            state_q <= IDLE;
          end else begin
            state_q     <= READ_WAIT;
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= id_q;
          end
        end
        READ_WAIT: state_q <= IDLE;
        default:   state_q <= IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  // The bank returns read data during READ_WAIT, so the response data is passed through.
  assign rsp_rdata = rsp_valid_q ? mem_rdata : '0;
  assign busy      = (state_q != IDLE);

endmodule

// File: doc/smem_access_scheduler.md
SMEM_ACCESS_SCHEDULER -- requirements
Module: smem_access_scheduler

Interface
REQ-001 Parameter Req_Width, default 10, number of requesters (CGRA PEs) sharing one memory bank.
REQ-002 Parameter ADDR_WIDTH, default 8, bank word-address width.
REQ-003 Parameter DATA_WIDTH, default 32, data word width.
REQ-004 clk  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 req  input  Req_Width  per-requester access request, level.
REQ-007 req_we  input  Req_Width  per-requester write enable: 1 = write, 0 = read.
REQ-008 req_addr  input  Req_Width*ADDR_WIDTH  flattened addresses; requester i uses slice i.
REQ-009 req_wdata  input  Req_Width*DATA_WIDTH  flattened write data; requester i uses slice i.
REQ-010 gnt  output  Req_Width  one-hot, one-cycle grant pulse; the request is accepted.
REQ-011 mem_en, mem_we  output  1 each  bank enable and write strobe.
REQ-012 mem_addr  output  ADDR_WIDTH; mem_wdata  output  DATA_WIDTH  bank address and write data.
REQ-013 mem_rdata  input  DATA_WIDTH  bank read data, valid one cycle after a mem_en read.
REQ-014 rsp_valid  output  1; rsp_id  output  clog2(Req_Width); rsp_rdata  output  DATA_WIDTH  read response.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have three states: IDLE, ACCESS and READ_WAIT.
REQ-017 IDLE with req != 0 SHALL select winner W round-robin, starting at ptr and wrapping Req_Width-1 -> 0, then go to ACCESS; with req == 0 it SHALL stay in IDLE.
REQ-018 On the IDLE->ACCESS edge the block SHALL register gnt = onehot(W) and mem_en = 1, plus mem_we, mem_addr and mem_wdata taken from slice W.
REQ-019 The same edge SHALL set ptr = (W+1) mod Req_Width.
REQ-020 In ACCESS, gnt and mem_* SHALL be driven for exactly one cycle; the next state SHALL be IDLE for a write and READ_WAIT for a read.
REQ-021 In READ_WAIT, rsp_valid = 1, rsp_id = W and rsp_rdata = mem_rdata for one cycle, then IDLE.
REQ-022 Outside ACCESS, gnt = 0 and mem_en = mem_we = 0; outside READ_WAIT, rsp_valid = 0.
REQ-023 Latency: gnt one cycle after the arbitrating IDLE cycle; read rsp_valid one cycle after gnt.
REQ-024 Throughput: one write per 2 cycles; one read per 3 cycles.
REQ-025 req, req_we, req_addr and req_wdata SHALL be ignored outside IDLE.
REQ-026 A requester that keeps req high after gnt SHALL be re-arbitrated as a new request at the rotated priority.
REQ-027 A requester holding req SHALL be granted within Req_Width arbitrations.
REQ-028 rsp_id and the ptr arithmetic SHALL use clog2(Req_Width) bits, with an explicit wrap at Req_Width (not a power of two).

Reset
REQ-029 While rst is high, the block SHALL force state = IDLE, ptr = 0, gnt = 0, mem_en = mem_we = 0, mem_addr = mem_wdata = 0, rsp_valid = 0, rsp_id = 0 and busy = 0.
REQ-030 A rst asserted in ACCESS or READ_WAIT SHALL abort the transaction, and no rsp_valid SHALL follow.
REQ-031 The first arbitration after reset SHALL give requester 0 highest priority.

Structure
REQ-032 The FSM state encodings and the default widths SHALL live in a shared package or header, smem_sched_pkg.
REQ-033 Winner selection SHALL be a combinational sub-module rr_pick (inputs req and ptr; outputs a one-hot and an index) using a masked/unmasked priority scheme.
REQ-034 The block SHALL be 120-400 lines of RTL.

Verification
REQ-035 After reset, req = 10'b0000001101, all writes, each requester dropping req after its gnt -> gnt SHALL be bits 0, 2, 3 on consecutive two-cycle slots.
REQ-036 With ptr = 9 and req = 10'b1000000001 -> gnt SHALL be bit 9, then bit 0.
REQ-037 Requester 2 writes 0xA5A5A5A5 to address 5, then requester 7 reads address 5 -> rsp_valid SHALL rise one cycle after gnt[7], with rsp_id = 7 and rsp_rdata = 0xA5A5A5A5.
REQ-038 Requesters 1 and 3 both holding req (writes) -> gnt SHALL alternate 1, 3, 1, 3.
REQ-039 rst raised in ACCESS of a read -> the next cycle SHALL show rsp_valid = 0, mem_en = 0 and busy = 0, and the next arbitration SHALL favour requester 0.
REQ-040 req = 0 for 20 cycles -> mem_en, gnt, rsp_valid and busy SHALL all stay 0.
